f_accum_expand: RTL
===================

Name: f_accum_expand

Overview:
- Inverse of the windowed max-accumulate reduction in the Versat datapath.
- Consumes one value per window (the reduced result) and re-expands it into a stream of stride+1 samples per window. This is nearest-neighbour upsample / broadcast.
- Sits after a reduction unit, or after memory holding reduced tensors; feeds elementwise units needing full-rate operands.
- Counts windows and flags completion for the accelerator controller.

Parameters:
DATA_W, 32, width of the data sample (sign bit is DATA_W-1).
STRIDE_W, 16, width of the window-length configuration.
DELAY_W, 7, width of the start-delay configuration.
COUNT_W, 16, width of the window-count configuration.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
run  input  1  single-cycle start pulse; reloads all configuration
running  input  1  datapath enable; all counters and registers advance only while high
strideMinusOne  input  STRIDE_W  samples per window minus one
windowsMinusOne  input  COUNT_W  windows per run minus one
delay0  input  DELAY_W  cycles to wait after run before the first capture
in0  input  DATA_W  reduced value, sampled on capture cycles only
out0  output  32  expanded sample, registered, latency 1, sign-extended from DATA_W
done  output  1  high once all windows have been emitted; cleared by run

Behaviour:
- Reset: state IDLE; delay_cnt, phase, win_cnt, held cleared; out0=0; done=0.
- FSM states: IDLE, WAIT, EMIT, DONE.
- run has priority over everything, in any state:
  - delay_cnt<=delay0, win_cnt<=0, done<=0, state<=WAIT.
  - out0 holds its value.
- WAIT, running=1:
  - if delay_cnt!=0: delay_cnt decrements.
  - else capture cycle: held<=in0, out0<=sext(in0), phase<=strideMinusOne, state<=EMIT.
  - First capture is therefore at cycle run+1+delay0.
- EMIT, running=1:
  - if phase!=0: phase decrements; out0<=sext(held).
  - else, if win_cnt!=windowsMinusOne: capture cycle as in WAIT; win_cnt increments.
  - else: state<=DONE, done<=1; out0 holds the last value.
- Capture cycles are spaced exactly strideMinusOne+1 cycles apart.
- Total valid samples per run = (strideMinusOne+1)*(windowsMinusOne+1).
- running=0: nothing changes (freeze), including in WAIT; run is still honoured.
- strideMinusOne=0: every EMIT cycle is a capture cycle (pass-through with latency 1).
- windowsMinusOne=0: a single window, then DONE.
- DONE: holds until run. No spontaneous restart.
- Configuration inputs are sampled only on run (stride also on each capture); mid-run changes to delay0/windowsMinusOne are ignored.
- Reset mid-operation returns immediately to reset values; the next run starts cleanly.
- Sign extension: out0[31:DATA_W] = value[DATA_W-1] when DATA_W<32.

Optional Feature:
F_ACCUM_EXPAND_UNPOOL_EN
- Enabled (max-unpool mode):
  - Adds input in1, width STRIDE_W: the argmax position within the window, sampled with in0 on capture cycles into held_idx.
  - Each emitted sample at window position p (p=0 on the capture cycle, p=strideMinusOne-phase afterwards) outputs sext(held) if p==held_idx, else 0.
  - held_idx>strideMinusOne yields an all-zero window.
- Disabled: in1 absent; pure broadcast as above.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit IDLE/WAIT/EMIT/DONE).
  - Sign-extension function.
  - Default width constants shared with the accumulate units.
- Natural sub-module: f_accum_expand_ctrl. It holds the delay/phase/window counters and FSM, and emits capture/emit/done strobes. The parent holds the held/held_idx/out0 data registers.

Test Plan:
- DATA_W=32, delay0=2, strideMinusOne=3, windowsMinusOne=1, in0=5 at first capture then -7 at second -> out0 = 5,5,5,5,-7,-7,-7,-7 from cycle run+4; done=1 one cycle after the 8th sample.
- strideMinusOne=0, windowsMinusOne=3, in0 ramp 1..4 -> out0 = 1,2,3,4 (latency 1); done after 4 samples.
- running deasserted for 3 cycles mid-window (stride 4) -> out0 frozen; sample count per window still 4; capture spacing extended by exactly 3.
- run asserted while in EMIT at window 1 of 3 -> counters reload, done stays 0, first capture at run+1+delay0; rst asserted mid-EMIT -> out0=0, done=0 immediately.
- DATA_W=16, in0=16'h8001 -> out0=32'hFFFF8001; in0=16'h7FFF -> out0=32'h00007FFF.
- UNPOOL_EN, strideMinusOne=3, in0=9, in1=2 -> out0 = 0,0,9,0; in1=5 -> 0,0,0,0.

Source files
------------

// File: rtl/f_accum_expand_pkg.sv
// Shared definitions for the windowed accumulate/expand units.
// State encoding, default widths and the sign-extension helper.
package f_accum_expand_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int STRIDE_W_DEF = 16;
    localparam int DELAY_W_DEF  = 7;
    localparam int COUNT_W_DEF  = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Bits at and above w are filled with bit w-1; w=32 passes v through.
    function automatic logic [31:0] sext32(input logic [31:0] v, input int w);
        logic [31:0] mask;
        logic [4:0]  msb;
        mask = 32'hFFFF_FFFF << w;
        msb  = 5'(w - 1);
        return v[msb] ? (v | mask) : (v & ~mask);
    endfunction

endpackage

// File: rtl/f_accum_expand_ctrl.sv
// Delay/phase/window counters and FSM for f_accum_expand.
// Emits capture/repeat strobes; F_ACCUM_EXPAND_UNPOOL_EN adds the position output.
module f_accum_expand_ctrl
    import f_accum_expand_pkg::*;
#(
    parameter int STRIDE_W = STRIDE_W_DEF,
    parameter int DELAY_W  = DELAY_W_DEF,
    parameter int COUNT_W  = COUNT_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_run,
    input  logic                i_running,
    input  logic [STRIDE_W-1:0] i_stride,
    input  logic [COUNT_W-1:0]  i_windows,
    input  logic [DELAY_W-1:0]  i_delay,
    output logic                o_capture,
    output logic                o_repeat,
`ifdef F_ACCUM_EXPAND_UNPOOL_EN
    output logic [STRIDE_W-1:0] o_pos,
`endif
    output logic                o_done
);

    logic [1:0]          r_state;
    logic [DELAY_W-1:0]  r_delay;
    logic [STRIDE_W-1:0] r_phase;
    logic [COUNT_W-1:0]  r_win;
    logic [COUNT_W-1:0]  r_wins;
    logic                r_done;
    logic                w_step;
    logic                w_last;
    logic                w_finish;

    assign w_step    = !i_run && i_running;
    assign w_last    = (r_win == r_wins);
    assign o_capture = w_step
                     && ((r_state == S_WAIT && r_delay == '0)
                      || (r_state == S_EMIT && r_phase == '0 && !w_last));
    assign o_repeat  = w_step && r_state == S_EMIT && r_phase != '0;
    assign w_finish  = w_step && r_state == S_EMIT && r_phase == '0 && w_last;
    assign o_done    = r_done;

`ifdef F_ACCUM_EXPAND_UNPOOL_EN
    logic [STRIDE_W-1:0] r_stride;

    // phase counts down from stride, so position is stride-phase+1 before decrement
    assign o_pos = o_capture ? '0 : (r_stride - r_phase + 1'b1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_stride <= '0;
        else if (o_capture)
            r_stride <= i_stride;
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_delay <= '0;
            r_phase <= '0;
            r_win   <= '0;
            r_wins  <= '0;
            r_done  <= 1'b0;
        end else if (i_run) begin
            r_delay <= i_delay;
            r_win   <= '0;
            r_wins  <= i_windows;
            r_done  <= 1'b0;
            r_state <= S_WAIT;
        end else begin
            if (w_step && r_state == S_WAIT && r_delay != '0)
                r_delay <= r_delay - 1'b1;
            if (o_capture) begin
                r_phase <= i_stride;
                r_state <= S_EMIT;
            end
            if (o_capture && r_state == S_EMIT)
                r_win <= r_win + 1'b1;
            if (o_repeat)
                r_phase <= r_phase - 1'b1;
            if (w_finish) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/f_accum_expand.sv
// Re-expands one reduced value per window into stride+1 samples.
// Define F_ACCUM_EXPAND_UNPOOL_EN for max-unpool mode (adds in1).
module f_accum_expand
    import f_accum_expand_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int STRIDE_W = STRIDE_W_DEF,
    parameter int DELAY_W  = DELAY_W_DEF,
    parameter int COUNT_W  = COUNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                running,
    input  logic [STRIDE_W-1:0] strideMinusOne,
    input  logic [COUNT_W-1:0]  windowsMinusOne,
    input  logic [DELAY_W-1:0]  delay0,
    input  logic [DATA_W-1:0]   in0,
`ifdef F_ACCUM_EXPAND_UNPOOL_EN
    input  logic [STRIDE_W-1:0] in1,
`endif
    output logic [31:0]         out0,
    output logic                done
);

    logic              w_cap;
    logic              w_rep;
    logic [DATA_W-1:0] r_held;
    logic [DATA_W-1:0] w_src;
    logic [31:0]       w_next;
    logic [31:0]       r_out0;

`ifdef F_ACCUM_EXPAND_UNPOOL_EN
    logic [STRIDE_W-1:0] w_pos;
    logic [STRIDE_W-1:0] r_idx;
    logic [STRIDE_W-1:0] w_idx;
`endif

    f_accum_expand_ctrl #(
        .STRIDE_W (STRIDE_W),
        .DELAY_W  (DELAY_W),
        .COUNT_W  (COUNT_W)
    ) u_ctrl (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_run     (run),
        .i_running (running),
        .i_stride  (strideMinusOne),
        .i_windows (windowsMinusOne),
        .i_delay   (delay0),
        .o_capture (w_cap),
        .o_repeat  (w_rep),
`ifdef F_ACCUM_EXPAND_UNPOOL_EN
        .o_pos     (w_pos),
`endif
        .o_done    (done)
    );

    assign w_src = w_cap ? in0 : r_held;

`ifdef F_ACCUM_EXPAND_UNPOOL_EN
    // only the argmax slot carries the value; an out-of-range index never matches
    assign w_idx  = w_cap ? in1 : r_idx;
    assign w_next = (w_pos == w_idx) ? sext32(32'(w_src), DATA_W) : 32'd0;
`else
    assign w_next = sext32(32'(w_src), DATA_W);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held <= '0;
            r_out0 <= '0;
`ifdef F_ACCUM_EXPAND_UNPOOL_EN
            r_idx  <= '0;
`endif
        end else begin
            if (w_cap) begin
                r_held <= in0;
`ifdef F_ACCUM_EXPAND_UNPOOL_EN
                r_idx  <= in1;
`endif
            end
            if (w_cap || w_rep)
                r_out0 <= w_next;
        end
    end

    assign out0 = r_out0;

endmodule
